nn_layer_scheduler: RTL and testbench
=====================================

Name: nn_layer_scheduler

Overview:
Controller that sequences one shared multiply-accumulate (MAC) datapath through a two-layer network. The first layer has N_IN inputs and N_HID hidden neurons; the second has N_HID inputs and N_OUT output neurons. The block issues weight-ROM addresses and operand indices, drives the MAC clear and enable strobes, and pulses result-writeback strobes. It sits between the board-level input/switch logic and the MAC, weight ROM and result registers. Its state code feeds a 7-segment debug digit.

Parameters:
N_IN, 10, inputs to the hidden layer
N_HID, 5, hidden neurons (also the number of inputs to the output layer)
N_OUT, 3, output neurons
AW, 7, weight-ROM address width; must satisfy 2^AW >= N_IN*N_HID + N_HID*N_OUT
ROM_LAT, 1, weight-ROM read latency in cycles (1..3)

Ports:
Clock  in  1  single clock; all state updates on its rising edge
Rst  in  1  asynchronous, active-high reset
start  in  1  run request; sampled only in IDLE
abort  in  1  synchronous cancel of a run in progress
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on successful completion
rom_addr  out  AW  weight-ROM address
op_layer  out  1  operand source: 0 = input buffer, 1 = hidden results
op_idx  out  4  operand index k for the current issue
issue  out  1  rom_addr and op_idx are valid this cycle
mac_clr  out  1  clear accumulator
mac_en  out  1  accumulate; this is issue delayed by ROM_LAT cycles
res_wr  out  1  write the accumulator to the result register
res_layer  out  1  0 = hidden result, 1 = output result
res_idx  out  3  neuron index j being written
state  out  4  current state code

Behaviour:
- Reset: all outputs 0, state IDLE(0), rom_addr 0, counters 0. Reset takes effect immediately, including mid-run. There is no partial writeback after reset.
- State codes: IDLE 0, L1_CLR 1, L1_MAC 2, L1_WB 3, L2_CLR 4, L2_MAC 5, L2_WB 6, DONE 7.
- IDLE: when start=1, go to L1_CLR next cycle, with j=0, k=0, rom_addr=0.
- L1_CLR: mac_clr=1 for 1 cycle, then L1_MAC.
- L1_MAC: issue=1 every cycle with op_layer=0, op_idx=k, rom_addr incremented after each issue. Stays N_IN cycles (k = 0..N_IN-1), then L1_WB.
- L1_WB: lasts ROM_LAT+1 cycles. mac_en is still draining during this time. res_wr=1 with res_layer=0, res_idx=j in the last cycle only. Then:
  - if j < N_HID-1: j++, go to L1_CLR;
  - otherwise: j=0, go to L2_CLR.
- L2_CLR, L2_MAC, L2_WB: same pattern, with op_layer=1, N_HID issues per neuron, N_OUT neurons, res_layer=1.
- Address continuity: rom_addr is never reset between layers. Layer-2 weights start at N_IN*N_HID (50 with defaults). The last address issued is N_IN*N_HID + N_HID*N_OUT - 1 (64).
- DONE: done=1 for 1 cycle, then IDLE.
- mac_en: exactly issue delayed by ROM_LAT cycles through a shift register. Total mac_en pulses per run = N_IN*N_HID + N_HID*N_OUT (65).
- Latency with defaults:
  - start sampled at edge 0; L1 occupies cycles 1..65 (13 per neuron);
  - L2 occupies cycles 66..89 (8 per neuron);
  - done is high in cycle 90; busy is high in cycles 1..90.
- start while busy: ignored, not queued. start held high through DONE starts a new run from the following IDLE cycle.
- abort (any non-IDLE state): next state IDLE. Same cycle: issue, res_wr and done are forced to 0. The mac_en pipeline is flushed to 0, so no done pulse appears. abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.
- Index widths: counters saturate only at their terminal counts; no wrap-around is reachable for legal parameters.

Decomposition:
- Package nn_ctrl_pkg holds:
  - the state enum (4-bit, codes above);
  - default N_IN, N_HID and N_OUT;
  - the localparam L2_BASE = N_IN*N_HID;
  - a function computing cycles per neuron.
- One sub-module, nn_loop_cnt: a counter with load, increment enable and a terminal-count flag. It is instantiated for k, for j, and for the ROM_LAT drain counter.

Test Plan:
- Reset then start=1 for 1 cycle (defaults) -> done pulse at cycle 90 only; busy high in cycles 1..90; 65 issue pulses with rom_addr 0..64 in order; 65 mac_en pulses each 1 cycle after their issue.
- Full run, monitor writebacks -> res_wr at cycles 13, 26, 39, 52, 65 (res_layer=0, res_idx 0..4), then at 73, 81, 89 (res_layer=1, res_idx 0..2); mac_clr precedes each neuron's first issue.
- abort at cycle 40 (L1) -> IDLE at cycle 41; no further issue, mac_en, res_wr or done; a new start gives a full correct run.
- Rst asserted asynchronously mid-L2, between edges -> all outputs 0 immediately; state=0; the run after release is correct.
- start held high continuously -> back-to-back runs; second run's L1_CLR in cycle 92; rom_addr restarts at 0.
- ROM_LAT=3 build -> each WB phase lasts 4 cycles; done at cycle 5*15 + 3*10 + 1 = 106; mac_en lags issue by 3 cycles.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : nn_ctrl_pkg
// Brief  : Shared types and defaults for the two-layer MAC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package nn_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_L1_CLR = 4'd1,
        ST_L1_MAC = 4'd2,
        ST_L1_WB  = 4'd3,
        ST_L2_CLR = 4'd4,
        ST_L2_MAC = 4'd5,
        ST_L2_WB  = 4'd6,
        ST_DONE   = 4'd7
    } state_t;

    localparam int DEF_N_IN  = 10;
    localparam int DEF_N_HID = 5;
    localparam int DEF_N_OUT = 3;
    localparam int L2_BASE   = DEF_N_IN * DEF_N_HID;

    // One clear cycle, n_in issues, then rom_lat+1 writeback cycles.
    function automatic int cycles_per_neuron(input int n_in, input int rom_lat);
        return n_in + rom_lat + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_loop_cnt.sv
`default_nettype none
// ============================================================================
// Module : nn_loop_cnt
// Brief  : Loadable up-counter that holds at its terminal count.
// Rev    : 1.0  initial release
// ============================================================================
module nn_loop_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != i_last)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_last);

endmodule
`default_nettype wire

// File: rtl/nn_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module : nn_layer_scheduler
// Brief  : Sequences one shared MAC through a two-layer network.
// Rev    : 1.0  initial release
// ============================================================================
module nn_layer_scheduler
    import nn_ctrl_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_HID   = DEF_N_HID,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int AW      = 7,
    parameter int ROM_LAT = 1
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    output logic          op_layer,
    output logic [3:0]    op_idx,
    output logic          issue,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          res_wr,
    output logic          res_layer,
    output logic [2:0]    res_idx,
    output logic [3:0]    state
);

    localparam logic [3:0] C_K_LAST_L1 = 4'(N_IN - 1);
    localparam logic [3:0] C_K_LAST_L2 = 4'(N_HID - 1);
    localparam logic [2:0] C_J_LAST_L1 = 3'(N_HID - 1);
    localparam logic [2:0] C_J_LAST_L2 = 3'(N_OUT - 1);
    localparam logic [1:0] C_D_LAST    = 2'(ROM_LAT);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic          w_l2, w_abort;
    logic          w_issue, w_clr, w_wr, w_done, w_addr_clr;
    logic          w_k_load, w_k_inc, w_k_tc;
    logic          w_j_load, w_j_inc, w_j_tc;
    logic          w_d_load, w_d_inc, w_d_tc;
    logic [3:0]    w_k;
    logic [2:0]    w_j;
    logic [1:0]    w_unused_d_cnt;

    assign w_l2    = (r_state == ST_L2_CLR) || (r_state == ST_L2_MAC) || (r_state == ST_L2_WB);
    assign w_abort = abort && (r_state != ST_IDLE);

    nn_loop_cnt #(.W(4)) u_k_cnt (
        .i_clk(CLOCK_50), .i_rst(rst), .i_load(w_k_load), .i_load_val(4'd0),
        .i_inc(w_k_inc), .i_last(w_l2 ? C_K_LAST_L2 : C_K_LAST_L1),
        .o_count(w_k), .o_tc(w_k_tc)
    );

    nn_loop_cnt #(.W(3)) u_j_cnt (
        .i_clk(CLOCK_50), .i_rst(rst), .i_load(w_j_load), .i_load_val(3'd0),
        .i_inc(w_j_inc), .i_last(w_l2 ? C_J_LAST_L2 : C_J_LAST_L1),
        .o_count(w_j), .o_tc(w_j_tc)
    );

    // Drain counter: writeback waits for the last ROM read to reach the MAC.
    nn_loop_cnt #(.W(2)) u_d_cnt (
        .i_clk(CLOCK_50), .i_rst(rst), .i_load(w_d_load), .i_load_val(2'd0),
        .i_inc(w_d_inc), .i_last(C_D_LAST),
        .o_count(w_unused_d_cnt), .o_tc(w_d_tc)
    );

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        w_clr      = 1'b0;
        w_wr       = 1'b0;
        w_done     = 1'b0;
        w_addr_clr = 1'b0;
        w_k_load   = 1'b0;
        w_k_inc    = 1'b0;
        w_j_load   = 1'b0;
        w_j_inc    = 1'b0;
        w_d_load   = 1'b0;
        w_d_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next     = ST_L1_CLR;
                    w_k_load   = 1'b1;
                    w_j_load   = 1'b1;
                    w_addr_clr = 1'b1;
                end
            end
            ST_L1_CLR, ST_L2_CLR: begin
                w_clr    = 1'b1;
                w_k_load = 1'b1;
                w_next   = w_l2 ? ST_L2_MAC : ST_L1_MAC;
            end
            ST_L1_MAC, ST_L2_MAC: begin
                w_issue = 1'b1;
                if (w_k_tc) begin
                    w_d_load = 1'b1;
                    w_next   = w_l2 ? ST_L2_WB : ST_L1_WB;
                end else begin
                    w_k_inc = 1'b1;
                end
            end
            ST_L1_WB, ST_L2_WB: begin
                if (w_d_tc) begin
                    w_wr = 1'b1;
                    if (w_j_tc) begin
                        w_j_load = 1'b1;
                        w_next   = w_l2 ? ST_DONE : ST_L2_CLR;
                    end else begin
                        w_j_inc = 1'b1;
                        w_next  = w_l2 ? ST_L2_CLR : ST_L1_CLR;
                    end
                end else begin
                    w_d_inc = 1'b1;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next  = ST_IDLE;
            w_issue = 1'b0;
            w_wr    = 1'b0;
            w_done  = 1'b0;
        end
    end

    // Weight addresses run straight through both layers; only a new run rewinds them.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_addr_clr) begin
            r_addr <= '0;
        end else if (w_issue) begin
            r_addr <= r_addr + AW'(1);
        end
    end

    generate
        if (ROM_LAT == 1) begin : g_lat1
            logic r_pipe;
            always_ff @(posedge CLOCK_50 or posedge rst) begin
                if (rst) begin
                    r_pipe <= 1'b0;
                end else if (w_abort) begin
                    r_pipe <= 1'b0;
                end else begin
                    r_pipe <= w_issue;
                end
            end
            assign mac_en = r_pipe;
        end else begin : g_latn
            logic [ROM_LAT-1:0] r_pipe;
            always_ff @(posedge CLOCK_50 or posedge rst) begin
                if (rst) begin
                    r_pipe <= '0;
                end else if (w_abort) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[ROM_LAT-2:0], w_issue};
                end
            end
            assign mac_en = r_pipe[ROM_LAT-1];
        end
    endgenerate

    assign busy      = (r_state != ST_IDLE);
    assign done      = w_done;
    assign rom_addr  = r_addr;
    assign op_layer  = w_l2;
    assign op_idx    = w_k;
    assign issue     = w_issue;
    assign mac_clr   = w_clr;
    assign res_wr    = w_wr;
    assign res_layer = w_l2;
    assign res_idx   = w_j;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_nn_layer_scheduler
// Brief  : Scoreboard bench for nn_layer_scheduler (ROM_LAT 1 and 3 instances).
// Rev    : 1.0  initial release
// ============================================================================
module tb_nn_layer_scheduler;
    import nn_ctrl_pkg::*;

    localparam int NI = DEF_N_IN;
    localparam int NH = DEF_N_HID;
    localparam int NO = DEF_N_OUT;
    localparam int K_ISS = 0, K_EN = 1, K_CLR = 2, K_WB = 3, K_DONE = 4;

    typedef struct { int dut; int kind; int cyc; int a; int b; int c; } ev_t;
    ev_t sb[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_s[2], abort_s[2], busy_s[2], done_s[2], issue_s[2];
    logic       mac_clr_s[2], mac_en_s[2], res_wr_s[2], op_layer_s[2], res_layer_s[2];
    logic [6:0] rom_addr_s[2];
    logic [3:0] op_idx_s[2], state_s[2];
    logic [2:0] res_idx_s[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        nn_layer_scheduler #(.ROM_LAT(g == 0 ? 1 : 3)) u_dut (
            .CLOCK_50(clk), .rst(rst), .start(start_s[g]), .abort(abort_s[g]),
            .busy(busy_s[g]), .done(done_s[g]), .rom_addr(rom_addr_s[g]),
            .op_layer(op_layer_s[g]), .op_idx(op_idx_s[g]), .issue(issue_s[g]),
            .mac_clr(mac_clr_s[g]), .mac_en(mac_en_s[g]), .res_wr(res_wr_s[g]),
            .res_layer(res_layer_s[g]), .res_idx(res_idx_s[g]), .state(state_s[g])
        );
    end

    // Every strobe seen must match the oldest pending expectation of its kind.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        always @(negedge clk) begin
            logic [4:0] obs;
            int oa, ob, oc, idx;
            if (!rst) begin
                obs = {done_s[g], res_wr_s[g], mac_clr_s[g], mac_en_s[g], issue_s[g]};
                for (int kd = 0; kd < 5; kd++) begin
                    if (obs[kd]) begin
                        oa = (kd == K_ISS) ? int'(rom_addr_s[g]) : (kd == K_WB) ? int'(res_layer_s[g]) : 0;
                        ob = (kd == K_ISS) ? int'(op_layer_s[g]) : (kd == K_WB) ? int'(res_idx_s[g]) : 0;
                        oc = (kd == K_ISS) ? int'(op_idx_s[g]) : 0;
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++)
                            if (idx < 0 && sb[i].dut == g && sb[i].kind == kd) idx = i;
                        n_checks++;
                        if (idx < 0) begin
                            n_errors++;
                            $display("FAIL unexpected_event dut%0d kind%0d at cyc %0d (none expected)", g, kd, cyc);
                        end else begin
                            if (sb[idx].cyc !== cyc || sb[idx].a !== oa || sb[idx].b !== ob || sb[idx].c !== oc) begin
                                n_errors++;
                                $display("FAIL event dut%0d kind%0d: got cyc %0d a %0d b %0d c %0d, want cyc %0d a %0d b %0d c %0d",
                                         g, kd, cyc, oa, ob, oc, sb[idx].cyc, sb[idx].a, sb[idx].b, sb[idx].c);
                            end
                            sb.delete(idx);
                        end
                    end
                end
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].dut == g && sb[i].cyc < cyc) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL missing_event dut%0d kind%0d: got nothing by cyc %0d, want at cyc %0d",
                                 g, sb[i].kind, cyc, sb[i].cyc);
                        sb.delete(i);
                    end
                end
            end
        end
    end

    // Expected strobes of one run whose start is sampled at edge e (first CLR at cyc e).
    task automatic push_run(input int g, input int e, input int lat);
        int   t, ni, nn, cpn;
        ev_t  ev;
        t = e;
        for (int layer = 0; layer < 2; layer++) begin
            ni  = (layer == 1) ? NH : NI;
            nn  = (layer == 1) ? NO : NH;
            cpn = cycles_per_neuron(ni, lat);
            for (int j = 0; j < nn; j++) begin
                ev = '{g, K_CLR, t, 0, 0, 0};
                sb.push_back(ev);
                for (int k = 0; k < ni; k++) begin
                    ev = '{g, K_ISS, t + 1 + k, ((layer == 1) ? L2_BASE + j * NH : j * NI) + k, layer, k};
                    sb.push_back(ev);
                    ev = '{g, K_EN, t + 1 + k + lat, 0, 0, 0};
                    sb.push_back(ev);
                end
                ev = '{g, K_WB, t + cpn - 1, layer, j, 0};
                sb.push_back(ev);
                t += cpn;
            end
        end
        ev = '{g, K_DONE, t, 0, 0, 0};
        sb.push_back(ev);
    endtask

    task automatic purge_after(input int g, input int a);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].dut == g && (sb[i].cyc > a ||
                (sb[i].cyc == a && (sb[i].kind == K_ISS || sb[i].kind == K_WB || sb[i].kind == K_DONE))))
                sb.delete(i);
    endtask

    function automatic int pending(input int g);
        int n = 0;
        for (int i = 0; i < sb.size(); i++) if (sb[i].dut == g) n++;
        return n;
    endfunction

    task automatic go_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input int g, input int lat, output int e);
        @(posedge clk);
        #1;
        start_s[g] = 1'b1;
        e = cyc + 1;
        push_run(g, e, lat);
        @(posedge clk);
        #1;
        start_s[g] = 1'b0;
    endtask

    // Runs to completion, tracking busy per cycle and the done cycle (cycle n <-> cyc e+n-1).
    task automatic run_and_check(input int g, input int lat, input int want_done, input string tag);
        int e, done_at;
        logic exp_busy;
        launch(g, lat, e);
        done_at = -1;
        for (int n = 1; n <= want_done + 5; n++) begin
            @(negedge clk);
            exp_busy = (n <= want_done);
            n_checks++;
            if (busy_s[g] !== exp_busy) begin
                n_errors++;
                $display("FAIL %s_busy cycle %0d: got %0b want %0b", tag, n, busy_s[g], exp_busy);
            end
            if (done_s[g] === 1'b1 && done_at < 0) done_at = n;
        end
        n_checks++;
        if (done_at !== want_done) begin
            n_errors++;
            $display("FAIL %s_done_cycle: got %0d want %0d", tag, done_at, want_done);
        end
        n_checks++;
        if (pending(g) !== 0) begin
            n_errors++;
            $display("FAIL %s_pending: got %0d outstanding events want 0", tag, pending(g));
        end
    endtask

    task automatic test_reset();
        #12;
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if ({busy_s[g], done_s[g], issue_s[g], mac_clr_s[g], mac_en_s[g], res_wr_s[g],
                 state_s[g], rom_addr_s[g]} !== 17'd0) begin
                n_errors++;
                $display("FAIL reset_outputs dut%0d: got busy %0b state %0d addr %0d, want all 0",
                         g, busy_s[g], state_s[g], rom_addr_s[g]);
            end
        end
        go_cycle(cyc + 2);
        rst = 1'b0;
        go_cycle(cyc + 2);
    endtask

    task automatic test_full_run();
        run_and_check(0, 1, 90, "full");
    endtask

    task automatic test_abort();
        int e;
        launch(0, 1, e);
        go_cycle(e + 39);
        purge_after(0, e + 39);
        abort_s[0] = 1'b1;
        go_cycle(e + 40);
        abort_s[0] = 1'b0;
        n_checks++;
        if (state_s[0] !== 4'd0) begin
            n_errors++;
            $display("FAIL abort_l1clr_state: got %0d want 0", state_s[0]);
        end
        go_cycle(e + 60);
        n_checks++;
        if (busy_s[0] !== 1'b0 || pending(0) !== 0) begin
            n_errors++;
            $display("FAIL abort_quiet: got busy %0b pending %0d want 0 0", busy_s[0], pending(0));
        end
        // Abort mid-MAC: the issue of that same cycle must be suppressed.
        launch(0, 1, e);
        go_cycle(e + 4);
        purge_after(0, e + 4);
        abort_s[0] = 1'b1;
        go_cycle(e + 5);
        abort_s[0] = 1'b0;
        n_checks++;
        if (state_s[0] !== 4'd0) begin
            n_errors++;
            $display("FAIL abort_mac_state: got %0d want 0", state_s[0]);
        end
        go_cycle(e + 15);
        run_and_check(0, 1, 90, "after_abort");
    endtask

    task automatic test_reset_mid_run();
        int e;
        launch(0, 1, e);
        go_cycle(e + 69);
        #3;
        rst = 1'b1;
        #1;
        purge_after(0, -1);
        n_checks++;
        if ({busy_s[0], done_s[0], issue_s[0], mac_clr_s[0], mac_en_s[0], res_wr_s[0],
             state_s[0], rom_addr_s[0], op_idx_s[0], res_idx_s[0]} !== 24'd0) begin
            n_errors++;
            $display("FAIL async_reset_outputs: got busy %0b state %0d addr %0d mac_en %0b, want all 0",
                     busy_s[0], state_s[0], rom_addr_s[0], mac_en_s[0]);
        end
        go_cycle(cyc + 2);
        rst = 1'b0;
        go_cycle(cyc + 2);
        run_and_check(0, 1, 90, "after_reset");
    endtask

    task automatic test_back_to_back();
        int e;
        @(posedge clk);
        #1;
        start_s[0] = 1'b1;
        e = cyc + 1;
        push_run(0, e, 1);
        push_run(0, e + 91, 1);
        go_cycle(e + 90);
        n_checks++;
        if (state_s[0] !== 4'd0) begin
            n_errors++;
            $display("FAIL b2b_idle_cycle91: got %0d want 0", state_s[0]);
        end
        go_cycle(e + 91);
        n_checks++;
        if (state_s[0] !== 4'd1) begin
            n_errors++;
            $display("FAIL b2b_clr_cycle92: got %0d want 1", state_s[0]);
        end
        go_cycle(e + 100);
        start_s[0] = 1'b0;
        go_cycle(e + 186);
        n_checks++;
        if (busy_s[0] !== 1'b0 || pending(0) !== 0) begin
            n_errors++;
            $display("FAIL b2b_end: got busy %0b pending %0d want 0 0", busy_s[0], pending(0));
        end
    endtask

    task automatic test_rom_lat3();
        run_and_check(1, 3, 106, "lat3");
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0;
            abort_s[g] = 1'b0;
        end
        test_reset();
        test_full_run();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_rom_lat3();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
